// File: rtl/pc_sequencer_pkg.sv
// Shared sequencing definitions for the FRANK6000 control unit and PC sequencer.
// Holds the jump-condition encodings, the decoded PC-update operation and defaults.
// Pure definitions: no state, no latency, no flow control.
package pc_sequencer_pkg;

    localparam int PCS_ADDR_WIDTH  = 8;
    localparam int PCS_STACK_DEPTH = 4;

    // Jump-condition encodings; the control unit emits these on j_mode.
    typedef enum logic [1:0] {
        JM_ALWAYS = 2'b00,
        JM_Z      = 2'b01,
        JM_C      = 2'b10,
        JM_NZ     = 2'b11
    } j_mode_e;

    // Decoded PC update chosen on a PCw strobe.
    typedef enum logic [2:0] {
        OP_INC      = 3'd0,  // pc + 1
        OP_JUMP     = 3'd1,  // pc <= target
        OP_CALL     = 3'd2,  // push pc + 1, pc <= target
        OP_CALL_OVF = 3'd3,  // call on a full stack: pc + 1, flag overflow
        OP_RET      = 3'd4,  // pc <= top of stack, pop
        OP_RET_UNF  = 3'd5   // return on an empty stack: pc + 1, flag underflow
    } seq_op_e;

    // Evaluate a jump condition against the status flags.
    function automatic logic jump_cond(input j_mode_e mode, input logic zero, input logic carry);
        logic res;
        unique case (mode)
            JM_ALWAYS: res = 1'b1;
            JM_Z:      res = zero;
            JM_C:      res = carry;
            JM_NZ:     res = ~zero;
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Sequencing bus between the control unit / status register and the PC sequencer.
// Wires only: no latency of its own.
// No handshake: i_PCw is the sole qualifier for every request on this bus.
//
// Signals: i_PCw strobe, i_jump/i_j_mode/i_call/i_return requests, i_target address,
//          i_zero/i_carry flags; o_pc, o_sp, stack full/empty and sticky error flags back.
interface pc_sequencer_if #(
    parameter int ADDR_WIDTH  = pc_sequencer_pkg::PCS_ADDR_WIDTH,
    parameter int STACK_DEPTH = pc_sequencer_pkg::PCS_STACK_DEPTH
);
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;

    logic                  i_PCw;
    logic                  i_jump;
    logic [1:0]            i_j_mode;
    logic                  i_call;
    logic                  i_return;
    logic [ADDR_WIDTH-1:0] i_target;
    logic                  i_zero;
    logic                  i_carry;

    logic [ADDR_WIDTH-1:0] o_pc;
    logic [SP_W-1:0]       o_sp;
    logic                  o_stack_full;
    logic                  o_stack_empty;
    logic                  o_overflow;
    logic                  o_underflow;

    // Control-unit side: drives requests, observes the PC and stack state.
    modport master (
        output i_PCw, i_jump, i_j_mode, i_call, i_return, i_target, i_zero, i_carry,
        input  o_pc, o_sp, o_stack_full, o_stack_empty, o_overflow, o_underflow
    );

    // Sequencer side.
    modport slave (
        input  i_PCw, i_jump, i_j_mode, i_call, i_return, i_target, i_zero, i_carry,
        output o_pc, o_sp, o_stack_full, o_stack_empty, o_overflow, o_underflow
    );

endinterface

// File: rtl/pc_sequencer_return_stack.sv
// Return-address LIFO: push stores at sp, pop exposes the entry below sp.
// Push/pop take effect on the next edge; o_top is a read of registered storage.
// No backpressure: a push when full and a pop when empty are silently dropped.
//
// Ports: i_clk, i_rst (sync, active-high), i_push/i_pop/i_data requests,
//        o_top (entry at sp-1), o_sp occupancy, o_full, o_empty.
module return_stack #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    localparam int IDX_W     = $clog2(DEPTH),
    localparam int SP_W      = IDX_W + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_top,
    output logic [SP_W-1:0]       o_sp,
    output logic                  o_full,
    output logic                  o_empty
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [SP_W-1:0]       sp;
    logic [SP_W-1:0]       sp_dec;
    logic                  do_push;
    logic                  do_pop;

    assign o_full  = (sp == SP_W'(DEPTH));
    assign o_empty = (sp == '0);

    // Pop wins if both are requested; the sequencer never asks for both at once.
    assign do_pop  = i_pop & ~o_empty;
    assign do_push = i_push & ~o_full & ~i_pop;

    // sp-1 wraps to all-ones when empty; that read is never consumed.
    assign sp_dec = sp - SP_W'(1);
    assign o_top  = mem[sp_dec[IDX_W-1:0]];
    assign o_sp   = sp;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_pop) begin
            sp <= sp_dec;
        end else if (do_push) begin
            // Not full, so sp < DEPTH and its low bits address a valid slot.
            mem[sp[IDX_W-1:0]] <= i_data;
            sp                 <= sp + SP_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and return-address stack of the FRANK6000 core.
// One-cycle latency: inputs sampled on a PCw edge, o_pc/o_sp update after it.
// No backpressure: with i_PCw low every piece of state holds.
//
// Ports: i_clk, i_rst (sync, active-high), bus (pc_sequencer_if.slave) carrying
//        the control-unit requests, status flags, PC, stack occupancy and error flags.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH  = PCS_ADDR_WIDTH,
    parameter int STACK_DEPTH = PCS_STACK_DEPTH,
    localparam int SP_W       = $clog2(STACK_DEPTH) + 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    pc_sequencer_if.slave  bus
);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] stk_top;
    logic [SP_W-1:0]       stk_sp;
    logic                  stk_full;
    logic                  stk_empty;
    logic                  stk_push;
    logic                  stk_pop;
    logic                  cond;
    logic                  overflow;
    logic                  underflow;
    seq_op_e               op;

    // Wraps modulo 2^ADDR_WIDTH, so a call from all-ones pushes 0.
    assign pc_inc = pc + ADDR_WIDTH'(1);
    assign cond   = jump_cond(j_mode_e'(bus.i_j_mode), bus.i_zero, bus.i_carry);

    // Priority: return, then qualified call, then qualified jump, else increment.
    // A call without jump, or with a false condition, falls through to increment.
    always_comb begin
        op = OP_INC;
        if (bus.i_return) begin
            op = stk_empty ? OP_RET_UNF : OP_RET;
        end else if (bus.i_call && bus.i_jump && cond) begin
            op = stk_full ? OP_CALL_OVF : OP_CALL;
        end else if (bus.i_jump && cond) begin
            op = OP_JUMP;
        end
    end

    // The stack sees its own reset, which already overrides these strobes.
    assign stk_push = bus.i_PCw && (op == OP_CALL);
    assign stk_pop  = bus.i_PCw && (op == OP_RET);

    return_stack #(
        .DATA_WIDTH (ADDR_WIDTH),
        .DEPTH      (STACK_DEPTH)
    ) u_stack (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (stk_push),
        .i_pop   (stk_pop),
        .i_data  (pc_inc),
        .o_top   (stk_top),
        .o_sp    (stk_sp),
        .o_full  (stk_full),
        .o_empty (stk_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (bus.i_PCw) begin
            unique case (op)
                OP_RET:      pc <= stk_top;
                OP_RET_UNF: begin
                    pc        <= pc_inc;
                    underflow <= 1'b1;
                end
                OP_CALL:     pc <= bus.i_target;
                OP_CALL_OVF: begin
                    pc       <= pc_inc;
                    overflow <= 1'b1;
                end
                OP_JUMP:     pc <= bus.i_target;
                default:     pc <= pc_inc;
            endcase
        end
    end

    assign bus.o_pc          = pc;
    assign bus.o_sp          = stk_sp;
    assign bus.o_stack_full  = stk_full;
    assign bus.o_stack_empty = stk_empty;
    assign bus.o_overflow    = overflow;
    assign bus.o_underflow   = underflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: table of vectors plus hand-written sequences.
// Each applied vector pushes its expected outputs; they are popped after the edge.
// Inputs change on the falling edge, outputs are sampled 1 time unit after rising.
module tb_pc_sequencer;

    localparam int AW = 8;
    localparam int SD = 4;

    typedef struct {
        bit       rst;
        bit       pcw;
        bit       jump;
        bit [1:0] jm;
        bit       call;
        bit       ret;
        bit [7:0] tgt;
        bit       z;
        bit       c;
        bit [7:0] epc;
        bit [2:0] esp;
        bit       eovf;
        bit       eunf;
    } vec_t;

    typedef struct {
        bit [7:0] pc;
        bit [2:0] sp;
        bit       full;
        bit       empty;
        bit       ovf;
        bit       unf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    vec_t tbl[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD)) bus ();

    pc_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    function automatic vec_t v(bit r, bit pcw, bit jump, bit [1:0] jm, bit call, bit ret,
                               bit [7:0] tgt, bit z, bit c,
                               bit [7:0] epc, bit [2:0] esp, bit eo, bit eu);
        vec_t t;
        t.rst = r; t.pcw = pcw; t.jump = jump; t.jm = jm; t.call = call; t.ret = ret;
        t.tgt = tgt; t.z = z; t.c = c;
        t.epc = epc; t.esp = esp; t.eovf = eo; t.eunf = eu;
        return t;
    endfunction

    task automatic check(string name, int step_no, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step_no, act, req);
        end
    endtask

    // Drive one vector for one clock, queue its expectation, compare after the edge.
    task automatic apply(vec_t t, int step_no);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst          = t.rst;
        bus.i_PCw    = t.pcw;
        bus.i_jump   = t.jump;
        bus.i_j_mode = t.jm;
        bus.i_call   = t.call;
        bus.i_return = t.ret;
        bus.i_target = t.tgt;
        bus.i_zero   = t.z;
        bus.i_carry  = t.c;
        e.pc    = t.epc;
        e.sp    = t.esp;
        e.full  = (t.esp == 3'(SD));
        e.empty = (t.esp == 3'd0);
        e.ovf   = t.eovf;
        e.unf   = t.eunf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard step %0d: got empty queue expected entry", step_no);
        end else begin
            got = sb.pop_front();
            check("pc",        step_no, int'(bus.o_pc),          int'(got.pc));
            check("sp",        step_no, int'(bus.o_sp),          int'(got.sp));
            check("full",      step_no, int'(bus.o_stack_full),  int'(got.full));
            check("empty",     step_no, int'(bus.o_stack_empty), int'(got.empty));
            check("overflow",  step_no, int'(bus.o_overflow),    int'(got.ovf));
            check("underflow", step_no, int'(bus.o_underflow),   int'(got.unf));
        end
    endtask

    initial begin
        bus.i_PCw = 0; bus.i_jump = 0; bus.i_j_mode = 0; bus.i_call = 0;
        bus.i_return = 0; bus.i_target = 0; bus.i_zero = 0; bus.i_carry = 0;

        //             rst pcw jmp jm    cal ret tgt    z  c   pc     sp o  u
        tbl.push_back(v(1, 0,  0, 2'd0, 0,  0,  8'h00, 0, 0,  8'h00, 0, 0, 0));
        // increment after reset
        tbl.push_back(v(0, 1,  0, 2'd0, 0,  0,  8'h00, 0, 0,  8'h01, 0, 0, 0));
        tbl.push_back(v(0, 1,  0, 2'd0, 0,  0,  8'h00, 0, 0,  8'h02, 0, 0, 0));
        tbl.push_back(v(0, 1,  0, 2'd0, 0,  0,  8'h00, 0, 0,  8'h03, 0, 0, 0));
        // conditional jumps, every j_mode taken and not taken
        tbl.push_back(v(0, 1,  1, 2'd0, 0,  0,  8'h05, 0, 0,  8'h05, 0, 0, 0));
        tbl.push_back(v(0, 1,  1, 2'd1, 0,  0,  8'h40, 1, 0,  8'h40, 0, 0, 0));
        tbl.push_back(v(0, 1,  1, 2'd1, 0,  0,  8'h40, 0, 0,  8'h41, 0, 0, 0));
        tbl.push_back(v(0, 1,  1, 2'd2, 0,  0,  8'h50, 0, 1,  8'h50, 0, 0, 0));
        tbl.push_back(v(0, 1,  1, 2'd2, 0,  0,  8'h50, 1, 0,  8'h51, 0, 0, 0));
        tbl.push_back(v(0, 1,  1, 2'd3, 0,  0,  8'h60, 0, 0,  8'h60, 0, 0, 0));
        tbl.push_back(v(0, 1,  1, 2'd3, 0,  0,  8'h60, 1, 1,  8'h61, 0, 0, 0));
        // call / return round trip, call without jump, call with false condition
        tbl.push_back(v(0, 1,  1, 2'd0, 0,  0,  8'h10, 0, 0,  8'h10, 0, 0, 0));
        tbl.push_back(v(0, 1,  1, 2'd0, 1,  0,  8'h80, 0, 0,  8'h80, 1, 0, 0));
        tbl.push_back(v(0, 1,  0, 2'd0, 0,  1,  8'h00, 0, 0,  8'h11, 0, 0, 0));
        tbl.push_back(v(0, 1,  0, 2'd0, 1,  0,  8'h99, 0, 0,  8'h12, 0, 0, 0));
        tbl.push_back(v(0, 1,  1, 2'd1, 1,  0,  8'h99, 0, 0,  8'h13, 0, 0, 0));
        // PCw low: hold despite a jump request
        tbl.push_back(v(0, 0,  1, 2'd0, 0,  0,  8'h77, 0, 0,  8'h13, 0, 0, 0));
        // nested calls to full, overflow, LIFO unwind (first return also has call+jump)
        tbl.push_back(v(0, 1,  1, 2'd0, 1,  0,  8'hA0, 0, 0,  8'hA0, 1, 0, 0));
        tbl.push_back(v(0, 1,  1, 2'd0, 1,  0,  8'hB0, 0, 0,  8'hB0, 2, 0, 0));
        tbl.push_back(v(0, 1,  1, 2'd0, 1,  0,  8'hC0, 0, 0,  8'hC0, 3, 0, 0));
        tbl.push_back(v(0, 1,  1, 2'd0, 1,  0,  8'h20, 0, 0,  8'h20, 4, 0, 0));
        tbl.push_back(v(0, 1,  1, 2'd0, 1,  0,  8'hE0, 0, 0,  8'h21, 4, 1, 0));
        tbl.push_back(v(0, 1,  1, 2'd0, 1,  1,  8'hEE, 0, 0,  8'hC1, 3, 1, 0));
        tbl.push_back(v(0, 1,  0, 2'd0, 0,  1,  8'h00, 0, 0,  8'hB1, 2, 1, 0));
        tbl.push_back(v(0, 1,  0, 2'd0, 0,  1,  8'h00, 0, 0,  8'hA1, 1, 1, 0));
        tbl.push_back(v(0, 1,  0, 2'd0, 0,  1,  8'h00, 0, 0,  8'h14, 0, 1, 0));
        // underflow at pc=FF wraps to 0; flags stay sticky
        tbl.push_back(v(0, 1,  1, 2'd0, 0,  0,  8'hFF, 0, 0,  8'hFF, 0, 1, 0));
        tbl.push_back(v(0, 1,  0, 2'd0, 0,  1,  8'h00, 0, 0,  8'h00, 0, 1, 1));
        tbl.push_back(v(0, 1,  0, 2'd0, 0,  0,  8'h00, 0, 0,  8'h01, 0, 1, 1));
        // plain increment wrap, and a call from FF pushes 0
        tbl.push_back(v(0, 1,  1, 2'd0, 0,  0,  8'hFF, 0, 0,  8'hFF, 0, 1, 1));
        tbl.push_back(v(0, 1,  0, 2'd0, 0,  0,  8'h00, 0, 0,  8'h00, 0, 1, 1));
        tbl.push_back(v(0, 1,  1, 2'd0, 0,  0,  8'hFF, 0, 0,  8'hFF, 0, 1, 1));
        tbl.push_back(v(0, 1,  1, 2'd0, 1,  0,  8'h30, 0, 0,  8'h30, 1, 1, 1));
        tbl.push_back(v(0, 1,  0, 2'd0, 0,  1,  8'h00, 0, 0,  8'h00, 0, 1, 1));
        // reset clears sticky flags; reset beats a call strobe
        tbl.push_back(v(1, 0,  0, 2'd0, 0,  0,  8'h00, 0, 0,  8'h00, 0, 0, 0));
        tbl.push_back(v(1, 1,  1, 2'd0, 1,  0,  8'h80, 0, 0,  8'h00, 0, 0, 0));
        tbl.push_back(v(0, 0,  1, 2'd0, 0,  0,  8'h55, 0, 0,  8'h00, 0, 0, 0));
        tbl.push_back(v(0, 1,  0, 2'd0, 0,  1,  8'h00, 0, 0,  8'h01, 0, 0, 1));
        tbl.push_back(v(1, 0,  0, 2'd0, 0,  0,  8'h00, 0, 0,  8'h00, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Reset mid-call with two entries stacked: stack must be empty afterwards.
        apply(v(0, 1, 1, 2'd0, 1, 0, 8'h10, 0, 0, 8'h10, 1, 0, 0), 100);
        apply(v(0, 1, 1, 2'd0, 1, 0, 8'h20, 0, 0, 8'h20, 2, 0, 0), 101);
        apply(v(1, 1, 1, 2'd0, 1, 0, 8'h30, 0, 0, 8'h00, 0, 0, 0), 102);
        apply(v(0, 1, 0, 2'd0, 0, 1, 8'h00, 0, 0, 8'h01, 0, 0, 1), 103);

        // PCw low for several cycles with random requests: everything holds.
        for (int k = 0; k < 6; k++) begin
            apply(v(0, 0, 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                    8'($urandom), 1'($urandom), 1'($urandom),
                    8'h01, 0, 0, 1), 200 + k);
        end

        // Push then hold: a held call request must not push again.
        apply(v(0, 1, 1, 2'd0, 1, 0, 8'h70, 0, 0, 8'h70, 1, 0, 1), 300);
        apply(v(0, 0, 1, 2'd0, 1, 0, 8'h90, 0, 0, 8'h70, 1, 0, 1), 301);
        apply(v(0, 1, 0, 2'd0, 0, 1, 8'h00, 0, 0, 8'h02, 0, 0, 1), 302);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
